key_ctrl: RTL and testbench
===========================

Name: key_ctrl

Overview:
Multi-button input controller for the clock's time-setting front panel. It shares one 1 ms prescaler across N_BTN per-button debounce/classification FSMs. For each button it produces a debounced level and single-cycle press, long-press, auto-repeat and release events, which the time-set logic consumes directly.

Parameters:
N_BTN, 4, number of buttons handled.
CK_PER_MS, 100000, ck cycles per 1 ms tick.
DEB_MS, 10, consecutive stable ms required to accept a press or release.
LONG_MS, 1000, ms held (after press accepted) before long_press fires.
REP_MS, 200, ms between repeat pulses after long_press.

Ports:
ck  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
btn_in  in  N_BTN  raw button levels, 1 = pushed.
btn_deb  out  N_BTN  debounced level per button.
press  out  N_BTN  1-cycle pulse when a press is accepted.
long_press  out  N_BTN  1-cycle pulse at LONG_MS of hold.
repeat  out  N_BTN  1-cycle pulse every REP_MS after long_press.
release  out  N_BTN  1-cycle pulse when a release is accepted.

Behaviour:
- Interface: one clock (ck). Reset rst_n is asynchronous, active-low.
- Reset: prescaler = 0, every FSM in IDLE, every ms counter = 0, all outputs 0. Assertion mid-operation aborts immediately; no release pulse is emitted.
- Prescaler: free-running count 0..CK_PER_MS-1. tick = 1 for one cycle when count == CK_PER_MS-1, then wraps to 0. Width is $clog2(CK_PER_MS).
- Per-button ms_cnt width: $clog2(max(DEB_MS, LONG_MS, REP_MS)+1). Increments only on tick and never wraps.
- Timing granularity is 1 tick. The first tick after a state entry may arrive 1..CK_PER_MS cycles later, so an N-ms interval lasts between (N-1)*CK_PER_MS+1 and N*CK_PER_MS cycles.
- In the rules below, "in" means the sampled btn_in bit.
- IDLE: btn_deb = 0. in = 1 -> PRESS_WAIT with ms_cnt = 0.
- PRESS_WAIT: btn_deb = 0.
  - in = 0 -> IDLE. This check takes priority over a tick in the same cycle; the glitch is rejected with no output.
  - On tick with in = 1, ms_cnt++. When ms_cnt reaches DEB_MS -> HELD, ms_cnt = 0, press = 1 on the transition cycle, btn_deb = 1 from the next cycle.
- HELD: btn_deb = 1.
  - in = 0 -> RELEASE_WAIT with ms_cnt = 0.
  - On tick, ms_cnt++. On reaching LONG_MS -> LONG_HELD, ms_cnt = 0, long_press = 1.
- LONG_HELD: btn_deb = 1.
  - in = 0 -> RELEASE_WAIT with ms_cnt = 0.
  - On tick, ms_cnt++. On reaching REP_MS: repeat = 1, ms_cnt = 0, stay in LONG_HELD.
- RELEASE_WAIT: btn_deb = 1.
  - in = 1 resets ms_cnt to 0 and stays in RELEASE_WAIT.
  - On tick with in = 0, ms_cnt++. On reaching DEB_MS -> IDLE, release = 1, btn_deb = 0 from the next cycle.
  - long_press and repeat are never asserted in this state.
- Outputs are registered; an event pulse appears the cycle after the deciding sample.
- Buttons are fully independent. Pulses on several bits in the same cycle are legal.
- Mutual exclusion: press, long_press, repeat and release are mutually exclusive per bit.
- Unused state encodings recover to IDLE.

Optional Feature:
KEY_SYNC_EN
- Defined: btn_in passes through a 2-flop synchronizer per bit, reset to 0, before the FSMs. All event latencies grow by 2 cycles.
- Undefined: btn_in feeds the FSMs directly; the caller must supply synchronous inputs.

Decomposition:
- Package key_pkg: state encoding constants (IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT; 3 bits) and the ms_cnt width function.
- Sub-module key_fsm: one button's FSM plus its ms_cnt. Inputs: ck, rst_n, in, tick. Outputs: the four event pulses and btn_deb.
- key_ctrl holds the shared prescaler, the optional synchronizer and a generate loop of N_BTN key_fsm instances.

Test Plan:
Bench params: CK_PER_MS=10, DEB_MS=3, LONG_MS=8, REP_MS=4; KEY_SYNC_EN undefined.
1. Clean press: btn_in[0]=1 held 50 cycles, then 0 -> press[0] exactly once 21..31 cycles after the rise; btn_deb[0]=1 next cycle; release[0] once 21..31 cycles after the fall; no long_press.
2. Glitch: btn_in[1]=1 for 15 cycles, then 0 -> no pulse on any output, btn_deb[1] stays 0.
3. Long hold: btn_in[2]=1 for 250 cycles -> press, then long_press about 80 cycles later, then repeat every 40 cycles (3 or 4 pulses), then release after the drop.
4. Release bounce: while HELD, btn_in toggles 0/1 every 5 cycles for 60 cycles, then stays 0 -> btn_deb stays 1 throughout the toggling; exactly one release, 21..31 cycles after the final fall.
5. Simultaneous: btn_in[0] and btn_in[3] rise on the same cycle -> press[0] and press[3] in the same cycle; the other bits stay 0.
6. Reset mid-hold: rst_n=0 while LONG_HELD -> all outputs 0 immediately, no release; after rst_n=1 with btn_in still 1, a new press arrives 21..31 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types for the front-panel key controller: FSM state encoding and ms counter sizing.
// Latency/backpressure: none (definitions only).
package key_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      LONG_HELD    = 3'd3,
      RELEASE_WAIT = 3'd4
   } key_state_e;

   // Counter must hold the largest interval it ever reaches before being cleared.
   function automatic int ms_cnt_w(input int deb_ms, input int long_ms, input int rep_ms);
      int m;
      m = deb_ms;
      if (long_ms > m) m = long_ms;
      if (rep_ms > m) m = rep_ms;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_fsm.sv
// One button: debounce plus press / long-press / repeat / release classification on the shared ms tick.
// Latency: every output is registered, one cycle after the deciding sample; no backpressure, pulses are fire-and-forget.
module key_fsm
   import key_pkg::*;
#(
   parameter int DEB_MS  = 10,
   parameter int LONG_MS = 1000,
   parameter int REP_MS  = 200
) (
   input  logic ck,
   input  logic rst_n,
   input  logic in,
   input  logic tick,
   output logic btn_deb,
   output logic press,
   output logic long_press,
   output logic repeat_evt,
   output logic release_evt
);

   localparam int MSW = ms_cnt_w(DEB_MS, LONG_MS, REP_MS);
   localparam logic [MSW-1:0] DEB_C  = MSW'(DEB_MS);
   localparam logic [MSW-1:0] LONG_C = MSW'(LONG_MS);
   localparam logic [MSW-1:0] REP_C  = MSW'(REP_MS);

   key_state_e     state_q, state_d;
   logic [MSW-1:0] ms_cnt_q, ms_cnt_d, ms_inc;
   logic           deb_q, deb_d;
   logic           press_q, press_d;
   logic           long_q, long_d;
   logic           rep_q, rep_d;
   logic           rel_q, rel_d;

   assign ms_inc = ms_cnt_q + MSW'(1);

   // A level change always wins over a tick arriving in the same cycle.
   always_comb begin
      state_d  = state_q;
      ms_cnt_d = ms_cnt_q;
      press_d  = 1'b0;
      long_d   = 1'b0;
      rep_d    = 1'b0;
      rel_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in) begin
               state_d  = PRESS_WAIT;
               ms_cnt_d = '0;
            end
         end
         PRESS_WAIT: begin
            if (!in) begin
               state_d  = IDLE;
               ms_cnt_d = '0;
            end else if (tick) begin
               if (ms_inc == DEB_C) begin
                  state_d  = HELD;
                  ms_cnt_d = '0;
                  press_d  = 1'b1;
               end else begin
                  ms_cnt_d = ms_inc;
               end
            end
         end
         HELD: begin
            if (!in) begin
               state_d  = RELEASE_WAIT;
               ms_cnt_d = '0;
            end else if (tick) begin
               if (ms_inc == LONG_C) begin
                  state_d  = LONG_HELD;
                  ms_cnt_d = '0;
                  long_d   = 1'b1;
               end else begin
                  ms_cnt_d = ms_inc;
               end
            end
         end
         LONG_HELD: begin
            if (!in) begin
               state_d  = RELEASE_WAIT;
               ms_cnt_d = '0;
            end else if (tick) begin
               if (ms_inc == REP_C) begin
                  ms_cnt_d = '0;
                  rep_d    = 1'b1;
               end else begin
                  ms_cnt_d = ms_inc;
               end
            end
         end
         RELEASE_WAIT: begin
            if (in) begin
               ms_cnt_d = '0;
            end else if (tick) begin
               if (ms_inc == DEB_C) begin
                  state_d  = IDLE;
                  ms_cnt_d = '0;
                  rel_d    = 1'b1;
               end else begin
                  ms_cnt_d = ms_inc;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            ms_cnt_d = '0;
         end
      endcase
      deb_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == RELEASE_WAIT);
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ms_cnt_q <= '0;
         deb_q    <= 1'b0;
         press_q  <= 1'b0;
         long_q   <= 1'b0;
         rep_q    <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ms_cnt_q <= ms_cnt_d;
         deb_q    <= deb_d;
         press_q  <= press_d;
         long_q   <= long_d;
         rep_q    <= rep_d;
         rel_q    <= rel_d;
      end
   end

   assign btn_deb     = deb_q;
   assign press       = press_q;
   assign long_press  = long_q;
   assign repeat_evt  = rep_q;
   assign release_evt = rel_q;

endmodule

// File: rtl/key_ctrl.sv
// Front-panel key controller: shared 1 ms prescaler feeding N_BTN key_fsm instances; KEY_SYNC_EN adds a 2-flop input synchronizer (+2 cycles).
// Latency: events one cycle after the deciding sample; no backpressure. repeat/release are SV keywords, hence the _evt port names.
module key_ctrl
   import key_pkg::*;
#(
   parameter int N_BTN     = 4,
   parameter int CK_PER_MS = 100000,
   parameter int DEB_MS    = 10,
   parameter int LONG_MS   = 1000,
   parameter int REP_MS    = 200
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_deb,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] long_press,
   output logic [N_BTN-1:0] repeat_evt,
   output logic [N_BTN-1:0] release_evt
);

   localparam int PW = (CK_PER_MS > 1) ? $clog2(CK_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CK_PER_MS - 1);

   logic [PW-1:0]    presc_q, presc_d;
   logic             tick;
   logic [N_BTN-1:0] btn_s;

   always_comb begin
      tick    = (presc_q == PRE_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
   end

`ifdef KEY_SYNC_EN
   logic [N_BTN-1:0] sync1_q, sync2_q;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   assign btn_s = sync2_q;
`else
   assign btn_s = btn_in;
`endif

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      key_fsm #(
         .DEB_MS (DEB_MS),
         .LONG_MS(LONG_MS),
         .REP_MS (REP_MS)
      ) u_fsm (
         .ck         (ck),
         .rst_n      (rst_n),
         .in         (btn_s[i]),
         .tick       (tick),
         .btn_deb    (btn_deb[i]),
         .press      (press[i]),
         .long_press (long_press[i]),
         .repeat_evt (repeat_evt[i]),
         .release_evt(release_evt[i])
      );
   end

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl: expected events are queued when a button is driven and matched against pulses seen on the outputs.
// Event kinds: 0 press, 1 long_press, 2 repeat, 3 release; a base of -1 times an event from the previous matched one.
module tb_key_ctrl;

   localparam int NB = 4;

   logic          ck = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_deb, press, long_press, repeat_evt, release_evt;

   typedef struct {
      int kind;
      int idx;
      int base;
      int lo;
      int hi;
   } exp_t;

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   excl   = 0;

   key_ctrl #(
      .N_BTN    (NB),
      .CK_PER_MS(10),
      .DEB_MS   (3),
      .LONG_MS  (8),
      .REP_MS   (4)
   ) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .btn_in     (btn_in),
      .btn_deb    (btn_deb),
      .press      (press),
      .long_press (long_press),
      .repeat_evt (repeat_evt),
      .release_evt(release_evt)
   );

   always #5 ck = ~ck;

   always @(posedge ck) cyc <= cyc + 1;

   always @(negedge ck) begin
      logic [3:0] ev;
      obs_t       o;
      for (int i = 0; i < NB; i++) begin
         ev = {release_evt[i], repeat_evt[i], long_press[i], press[i]};
         if ($countones(ev) > 1) excl++;
         for (int k = 0; k < 4; k++) begin
            if (ev[k]) begin
               o.kind = k;
               o.idx  = i;
               o.cyc  = cyc;
               obs_q.push_back(o);
            end
         end
      end
   end

   task automatic tk(input int n);
      repeat (n) @(posedge ck);
      #1;
   endtask

   task automatic chk(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic chk_win(input string tag, input int observed, input int lo, input int hi);
      checks++;
      assert ((observed >= lo && observed <= hi) === 1'b1)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d..%0d", tag, observed, lo, hi);
      end
   endtask

   task automatic push(input int kind, input int idx, input int base, input int lo, input int hi);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.base = base;
      e.lo   = lo;
      e.hi   = hi;
      exp_q.push_back(e);
   endtask

   task automatic check_events(input string tag);
      exp_t e;
      obs_t o;
      int   prev;
      int   base;
      prev = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, " event present"}, int'(obs_q.size() > 0), 1);
         if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk({tag, " kind"}, o.kind, e.kind);
            chk({tag, " button"}, o.idx, e.idx);
            base = (e.base < 0) ? prev : e.base;
            chk_win({tag, " delay"}, o.cyc - base, e.lo, e.hi);
            prev = o.cyc;
         end
      end
      chk({tag, " extra events"}, obs_q.size(), 0);
      obs_q.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      btn_in = '0;
      tk(3);
      chk("reset outputs", int'({btn_deb, press, long_press, repeat_evt, release_evt}), 0);
      rst_n = 1'b1;
      tk(5);

      // 1: clean press and release on button 0
      btn_in[0] = 1'b1;
      push(0, 0, cyc, 21, 31);
      tk(15);
      chk("s1 deb during debounce", int'(btn_deb[0]), 0);
      tk(35);
      chk("s1 deb held", int'(btn_deb[0]), 1);
      btn_in[0] = 1'b0;
      push(3, 0, cyc, 21, 31);
      tk(40);
      chk("s1 deb after release", int'(btn_deb[0]), 0);
      check_events("s1");

      // 2: short glitch on button 1 is rejected
      btn_in[1] = 1'b1;
      tk(15);
      btn_in[1] = 1'b0;
      tk(40);
      chk("s2 deb", int'(btn_deb[1]), 0);
      check_events("s2");

      // 3: long hold on button 2 -> press, long_press, three repeats, release
      btn_in[2] = 1'b1;
      push(0, 2, cyc, 21, 31);
      push(1, 2, -1, 80, 80);
      push(2, 2, -1, 40, 40);
      push(2, 2, -1, 40, 40);
      push(2, 2, -1, 40, 40);
      tk(250);
      btn_in[2] = 1'b0;
      push(3, 2, cyc, 21, 31);
      tk(40);
      check_events("s3");

      // 4: release bounce on button 1
      btn_in[1] = 1'b1;
      push(0, 1, cyc, 21, 31);
      tk(40);
      chk("s4 deb held", int'(btn_deb[1]), 1);
      for (int s = 0; s < 12; s++) begin
         btn_in[1] = s[0];
         tk(5);
         chk("s4 deb bouncing", int'(btn_deb[1]), 1);
      end
      btn_in[1] = 1'b0;
      push(3, 1, cyc, 21, 31);
      tk(40);
      chk("s4 deb after release", int'(btn_deb[1]), 0);
      check_events("s4");

      // 5: buttons 0 and 3 together
      btn_in[0] = 1'b1;
      btn_in[3] = 1'b1;
      push(0, 0, cyc, 21, 31);
      push(0, 3, -1, 0, 0);
      tk(40);
      chk("s5 deb", int'(btn_deb), 9);
      btn_in[0] = 1'b0;
      btn_in[3] = 1'b0;
      push(3, 0, cyc, 21, 31);
      push(3, 3, -1, 0, 0);
      tk(40);
      check_events("s5");

      // 6: reset while button 2 is in long hold
      btn_in[2] = 1'b1;
      push(0, 2, cyc, 21, 31);
      push(1, 2, -1, 80, 80);
      tk(130);
      chk("s6 deb before reset", int'(btn_deb[2]), 1);
      rst_n = 1'b0;
      #1;
      chk("s6 outputs in reset", int'({btn_deb, press, long_press, repeat_evt, release_evt}), 0);
      check_events("s6 pre-reset");
      tk(3);
      chk("s6 deb during reset", int'(btn_deb), 0);
      rst_n = 1'b1;
      push(0, 2, cyc, 21, 31);
      tk(40);
      check_events("s6 after reset");
      btn_in[2] = 1'b0;
      push(3, 2, cyc, 21, 31);
      tk(40);
      check_events("s6 release");

      chk("final deb", int'(btn_deb), 0);
      chk("event exclusivity", excl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
